// File: rtl/alu_op_dispatch.sv
// Registered opcode dispatcher for the 8-bit ALU: valid/ready accept, one-hot unit enables, multi-cycle mul.
// Optional illegal-opcode counter is built when ALU_DISPATCH_ILLEGAL_CNT_EN is defined.
module alu_op_dispatch #(
   parameter int OP_W    = 3,
   parameter int MUL_LAT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [OP_W-1:0] op,
   output logic            en_add,
   output logic            en_sub,
   output logic            en_mul,
   output logic            en_logic,
   output logic [1:0]      logic_sel,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic [7:0]      illegal_cnt
);
   localparam int CNT_W = $clog2(MUL_LAT + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             dec_add, dec_sub, dec_mul, dec_logic, dec_ill;
   logic [1:0]       dec_sel;

   always_comb begin
      dec_add   = (op == OP_W'(0));
      dec_sub   = (op == OP_W'(1));
      dec_mul   = (op == OP_W'(2));
      dec_logic = (op >= OP_W'(3)) && (op <= OP_W'(6));
      dec_ill   = (op >= OP_W'(7));
      // codes 3..6 map onto logic functions 0..3
      dec_sel   = op[1:0] - 2'd3;
   end

   assign op_ready = (state == S_IDLE) && !rst;
   assign busy     = (state != S_IDLE);
   assign accept   = op_valid && op_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         en_add    <= 1'b0;
         en_sub    <= 1'b0;
         en_mul    <= 1'b0;
         en_logic  <= 1'b0;
         logic_sel <= 2'd0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         en_add   <= 1'b0;
         en_sub   <= 1'b0;
         en_mul   <= 1'b0;
         en_logic <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (dec_ill) begin
                     illegal <= 1'b1;
                  end else if (dec_mul) begin
                     state  <= S_MUL;
                     cnt    <= CNT_W'(MUL_LAT - 1);
                     en_mul <= 1'b1;
                     done   <= (MUL_LAT == 1);
                  end else begin
                     state    <= S_EXEC;
                     en_add   <= dec_add;
                     en_sub   <= dec_sub;
                     en_logic <= dec_logic;
                     done     <= 1'b1;
                     if (dec_logic) logic_sel <= dec_sel;
                  end
               end
            end
            S_EXEC: state <= S_IDLE;
            S_MUL: begin
               // done is registered, so it is raised on the edge that makes cnt reach zero
               if (cnt != '0) begin
                  cnt    <= cnt - 1'b1;
                  en_mul <= 1'b1;
                  done   <= (cnt == CNT_W'(1));
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_DISPATCH_ILLEGAL_CNT_EN
   logic [7:0] ill_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         ill_cnt_q <= 8'd0;
      else if (accept && dec_ill && (ill_cnt_q != 8'hFF))
         ill_cnt_q <= ill_cnt_q + 8'd1;
   end

   assign illegal_cnt = ill_cnt_q;
`else
   assign illegal_cnt = 8'd0;
`endif

endmodule

// File: doc/alu_op_dispatch.md
# alu_op_dispatch

Registered opcode dispatcher for the 8-bit ALU, replacing the purely combinational select decode. It accepts one opcode per transaction over a valid/ready handshake and drives one-hot, registered unit enables. The multiplier enable is held for a parametrised number of cycles, and completion is signalled by a `done` pulse. Illegal opcodes are flagged and counted. It sits between the instruction/control source and the add, sub, mul and logic datapath units.

## Interface
- `OP_W`, default 3: opcode width; must be ≥ 3.
- `MUL_LAT`, default 4: multiplier occupancy in cycles; must be ≥ 1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `op_valid` in 1: `op` is valid this cycle.
- `op_ready` out 1: dispatcher can accept; equals (state==IDLE) && !`rst`.
- `op` in `OP_W`: opcode.
- `en_add` out 1: adder enable.
- `en_sub` out 1: subtractor enable.
- `en_mul` out 1: multiplier enable.
- `en_logic` out 1: logic-unit enable.
- `logic_sel` out 2: logic function index, valid while `en_logic`=1.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: one-cycle illegal-opcode pulse.
- `illegal_cnt` out 8: saturating count of illegal opcodes.

## Operation
- Accept occurs on a cycle where `op_valid` && `op_ready`. The opcode is captured on that edge.
- Opcode decode (zero-extended when `OP_W` > 3):
  - 0 → add
  - 1 → sub
  - 2 → mul
  - 3, 4, 5, 6 → logic, with `logic_sel` = 0, 1, 2, 3 respectively
  - 7 and all codes above 7 → illegal
- FSM states: IDLE, EXEC, MUL.
  - IDLE + accept of add/sub/logic → EXEC.
  - IDLE + accept of mul → MUL. The counter loads `MUL_LAT`-1.
  - IDLE + accept of illegal → stay in IDLE. Pulse `illegal`. Increment `illegal_cnt`.
  - EXEC → IDLE unconditionally.
  - MUL: stay while counter ≠ 0, decrementing each cycle. Go to IDLE when counter = 0.
- Enables are registered and one-hot. At most one enable is high in any cycle. All enables are 0 in IDLE.
- `en_mul` is high for every MUL cycle.
- `done` is high in EXEC, and in the MUL cycle where counter = 0.
- `op_valid` while `busy` is ignored. `op` is not sampled. The source must hold `op_valid` and `op` until accepted.
- `illegal_cnt` saturates at 255 and does not wrap.
- Counter width is $clog2(`MUL_LAT`+1).
- Reset values: state IDLE, all enables 0, `logic_sel` 0, `busy` 0, `done` 0, `illegal` 0, `illegal_cnt` 0, counter 0.
- `rst` mid-operation aborts the transaction. No `done` is issued for it.

## Timing
- Accept at edge T. For add/sub/logic: enable and `done` high in cycle T+1. `op_ready` high again at T+2, giving one accept every 2 cycles.
- Mul accepted at T: `en_mul` high for cycles T+1 … T+`MUL_LAT`. `done` is high at T+`MUL_LAT`. `op_ready` is high at T+`MUL_LAT`+1.
- With `MUL_LAT`=1, mul timing is identical to add.
- Illegal accepted at T: `illegal` high at T+1. `op_ready` stays high, so a legal op can be accepted at T+1.
- `done` and `illegal` are never high in the same cycle.
- `op_ready` is 0 in every cycle where `rst`=1, and is 1 in the first cycle after `rst` deasserts.

## Configuration
- Macro: `ALU_DISPATCH_ILLEGAL_CNT_EN`.
- Defined: `illegal_cnt` is implemented as specified above.
- Undefined: the counter register is not built and `illegal_cnt` is tied to 8'd0. The `illegal` pulse and all other behaviour are unchanged.

## Test plan
- Reset, then `op`=0 with `op_valid` held high → `en_add`=1 and `done`=1 one cycle after accept. `op_ready` returns high one cycle later. Accepts occur every 2 cycles.
- `MUL_LAT`=4, `op`=2 accepted at T → `en_mul` high for exactly T+1..T+4, `done` at T+4 only. `op_valid` with `op`=0 during T+1..T+4 is not accepted; it is accepted at T+5.
- `op`=3, 4, 5, 6 in sequence → `en_logic`=1 each time, with `logic_sel`=0, 1, 2, 3 and no other enable.
- `op`=7 repeated 260 times back-to-back → `illegal` pulses each cycle, no enables, no `done`, `illegal_cnt` stops at 255. Without the macro, `illegal_cnt` stays 0.
- `rst` asserted during MUL cycle 2 → next cycle: all enables 0, `busy` 0, no `done`. `op_ready`=0 while `rst`=1, then 1 after it deasserts.
- `OP_W`=5, `op`=5'd18 → `illegal` pulse. `op`=5'd1 → `en_sub`.
